disparity_monitor: RTL and testbench

- Multi-lane running-disparity checker for the IEEE1149.10 8b/10b receive path; generalises the single-lane encoder disparity tracker.
- Per lane: tracks running disparity (RD), flags disparity and unbalanced-symbol errors, keeps a saturating error count and runs a lock FSM.
- Sits after the 10b symbol aligner and before the 8b/10b decoder. Status feeds the link-health CSRs.

---
 rtl/disparity_monitor.sv | 124 ++++++++++++
 tb/tb_disparity_monitor.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/disparity_monitor.sv
// Multi-lane 8b/10b running-disparity checker with per-lane error counters and lock FSM.
// Define DISP_MON_SUBBLOCK_CHECK_EN to add 6b/4b sub-block checking and the code_err output.
module disparity_monitor #(
  parameter int LANES     = 4,
  parameter int CNT_W     = 8,
  parameter int LOCK_GOOD = 16,
  parameter int LOSS_ERR  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [10*LANES-1:0]    sym_in,
  input  logic [LANES-1:0]       sym_vld,
  input  logic                   cnt_clr,
  output logic [LANES-1:0]       rd_out,
  output logic [LANES-1:0]       disp_err,
  output logic [LANES-1:0]       bal_err,
  output logic [LANES-1:0]       lock,
`ifdef DISP_MON_SUBBLOCK_CHECK_EN
  output logic [LANES-1:0]       code_err,
`endif
  output logic [CNT_W*LANES-1:0] err_cnt
);

  localparam int RUN_MAX = (LOCK_GOOD > LOSS_ERR) ? LOCK_GOOD : LOSS_ERR;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] GOOD_M = RUN_W'(LOCK_GOOD);
  localparam logic [RUN_W-1:0] LOSS_M = RUN_W'(LOSS_ERR);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // lock output is the registered FSM state, so it doubles as the state debug view
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} lock_state_t;

  function automatic logic [3:0] popcount(input logic [9:0] v);
    logic [3:0] c;
    c = '0;
    for (int b = 0; b < 10; b++) c = c + 4'(v[b]);
    return c;
  endfunction

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [9:0]       sym;
    logic [3:0]       ones;
    logic             sym_disp;
    logic             sym_bal;
    logic             sym_code;
    logic             sym_err;
    logic             rd_q;
    logic             disp_q;
    logic             bal_q;
    logic             code_q;
    lock_state_t      state;
    logic [RUN_W-1:0] run;
    logic [CNT_W-1:0] cnt;

    assign sym  = sym_in[10*i +: 10];
    assign ones = popcount(sym);

    // rd_q = 1 means RD-; a 6-ones symbol needs RD-, a 4-ones symbol needs RD+
    always_comb begin
      sym_bal  = (ones < 4'd4) || (ones > 4'd6);
      sym_disp = ((ones == 4'd6) && !rd_q) || ((ones == 4'd4) && rd_q);
`ifdef DISP_MON_SUBBLOCK_CHECK_EN
      sym_code = (popcount({4'b0, sym[9:4]}) < 4'd2) || (popcount({4'b0, sym[9:4]}) > 4'd4) ||
                 (popcount({6'b0, sym[3:0]}) < 4'd1) || (popcount({6'b0, sym[3:0]}) > 4'd3);
`else
      sym_code = 1'b0;
`endif
      sym_err  = sym_disp | sym_bal | sym_code;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q   <= 1'b1;
        disp_q <= 1'b0;
        bal_q  <= 1'b0;
        code_q <= 1'b0;
        state  <= HUNT;
        run    <= '0;
        cnt    <= '0;
      end else begin
        disp_q <= sym_vld[i] & sym_disp;
        bal_q  <= sym_vld[i] & sym_bal;
        code_q <= sym_vld[i] & sym_code;
        if (sym_vld[i]) begin
          // an illegal 6/4 symbol still resyncs RD to what the symbol implies
          if (ones == 4'd6) rd_q <= 1'b0;
          else if (ones == 4'd4) rd_q <= 1'b1;
          case (state)
            HUNT: begin
              if (sym_err) run <= '0;
              else if (run + 1'b1 == GOOD_M) begin
                state <= LOCKED;
                run   <= '0;
              end else run <= run + 1'b1;
            end
            LOCKED: begin
              if (!sym_err) run <= '0;
              else if (run + 1'b1 == LOSS_M) begin
                state <= HUNT;
                run   <= '0;
              end else run <= run + 1'b1;
            end
            default: begin
              state <= HUNT;
              run   <= '0;
            end
          endcase
        end
        if (cnt_clr) cnt <= '0;
        else if (sym_vld[i] && sym_err && cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end
    end

    assign rd_out[i]                  = rd_q;
    assign disp_err[i]                = disp_q;
    assign bal_err[i]                 = bal_q;
    assign lock[i]                    = (state == LOCKED);
    assign err_cnt[CNT_W*i +: CNT_W]  = cnt;
`ifdef DISP_MON_SUBBLOCK_CHECK_EN
    assign code_err[i]                = code_q;
`endif
  end

endmodule

// File: tb/tb_disparity_monitor.sv
// Scoreboard bench for disparity_monitor: driver pushes model predictions, monitor pops and compares.
module tb_disparity_monitor;
  localparam int LANES     = 4;
  localparam int CNT_W     = 8;
  localparam int LOCK_GOOD = 16;
  localparam int LOSS_ERR  = 4;
  localparam int CNT_TOP   = (1 << CNT_W) - 1;
  localparam int O_RD   = 0;
  localparam int O_DISP = LANES;
  localparam int O_BAL  = 2*LANES;
  localparam int O_LOCK = 3*LANES;
  localparam int O_CODE = 4*LANES;
  localparam int O_CNT  = 5*LANES;
  localparam int EW     = 5*LANES + CNT_W*LANES;

  localparam logic [9:0] K_M  = 10'b0011111010;
  localparam logic [9:0] K_P  = 10'b1100000101;
  localparam logic [9:0] BAD0 = 10'b0000000000;
  localparam logic [9:0] BAL7 = 10'b1111111000;

  logic                   clk;
  logic                   rst;
  logic [10*LANES-1:0]    sym_in;
  logic [LANES-1:0]       sym_vld;
  logic                   cnt_clr;
  logic [LANES-1:0]       rd_out;
  logic [LANES-1:0]       disp_err;
  logic [LANES-1:0]       bal_err;
  logic [LANES-1:0]       lock;
  logic [CNT_W*LANES-1:0] err_cnt;
  logic [LANES-1:0]       code_act;
`ifdef DISP_MON_SUBBLOCK_CHECK_EN
  logic [LANES-1:0]       code_err;
  assign code_act = code_err;
`else
  assign code_act = '0;
`endif

  disparity_monitor #(
    .LANES(LANES), .CNT_W(CNT_W), .LOCK_GOOD(LOCK_GOOD), .LOSS_ERR(LOSS_ERR)
  ) dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_vld(sym_vld), .cnt_clr(cnt_clr),
    .rd_out(rd_out), .disp_err(disp_err), .bal_err(bal_err), .lock(lock),
`ifdef DISP_MON_SUBBLOCK_CHECK_EN
    .code_err(code_err),
`endif
    .err_cnt(err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int  total = 0;
  int  bad = 0;
  bit  running = 1'b1;

  // reference model: RD as a bit (1 = RD-), lock as bool, runs and counts as integers
  bit m_rd[LANES];
  bit m_locked[LANES];
  int m_run[LANES];
  int m_cnt[LANES];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // driver: apply one cycle of inputs, advance the model, queue the expected outputs
  task automatic step(input logic r, input logic [LANES-1:0] v,
                      input logic [10*LANES-1:0] s, input logic c);
    logic [EW-1:0] e;
    logic [9:0] sy;
    int ones, o6, o4;
    bit d, b, ce, err;
    rst = r; sym_vld = v; sym_in = s; cnt_clr = c;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r) begin
        m_rd[i] = 1'b1; m_locked[i] = 1'b0; m_run[i] = 0; m_cnt[i] = 0;
      end else begin
        if (v[i]) begin
          sy   = s[10*i +: 10];
          ones = $countones(sy);
          o6   = $countones(sy[9:4]);
          o4   = $countones(sy[3:0]);
          b    = (ones < 4) || (ones > 6);
          d    = (ones == 6 && !m_rd[i]) || (ones == 4 && m_rd[i]);
`ifdef DISP_MON_SUBBLOCK_CHECK_EN
          ce   = (o6 < 2) || (o6 > 4) || (o4 < 1) || (o4 > 3);
`else
          ce   = 1'b0;
`endif
          err  = d || b || ce;
          if (ones == 6) m_rd[i] = 1'b0;
          if (ones == 4) m_rd[i] = 1'b1;
          e[O_DISP+i] = d;
          e[O_BAL+i]  = b;
          e[O_CODE+i] = ce;
          if (err && m_cnt[i] < CNT_TOP) m_cnt[i]++;
          if (!m_locked[i]) begin
            m_run[i] = err ? 0 : m_run[i] + 1;
            if (m_run[i] == LOCK_GOOD) begin m_locked[i] = 1'b1; m_run[i] = 0; end
          end else begin
            m_run[i] = err ? m_run[i] + 1 : 0;
            if (m_run[i] == LOSS_ERR) begin m_locked[i] = 1'b0; m_run[i] = 0; end
          end
        end
        if (c) m_cnt[i] = 0;
      end
      e[O_RD+i]   = m_rd[i];
      e[O_LOCK+i] = m_locked[i];
      e[O_CNT+CNT_W*i +: CNT_W] = CNT_W'(m_cnt[i]);
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic send(input int lane, input logic [9:0] sy, input logic c);
    logic [10*LANES-1:0] s;
    logic [LANES-1:0] v;
    s = '0; v = '0;
    s[10*lane +: 10] = sy;
    v[lane] = 1'b1;
    step(1'b0, v, s, c);
  endtask

  function automatic logic [9:0] good_sym(input int lane);
    return m_rd[lane] ? K_M : K_P;
  endfunction

  function automatic logic [9:0] rand_sym(input int lane);
    int r;
    logic [9:0] n5;
    r = $urandom_range(0, 99);
    n5 = 10'b0101010101;
    if (r < 55) return good_sym(lane);
    if (r < 75) return (r[0]) ? n5 : 10'b1110001100;
    if (r < 85) return m_rd[lane] ? K_P : K_M;
    return 10'($urandom_range(0, 1023));
  endfunction

  // monitor: outputs are always presented, so one queued entry is consumed per clock
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (running) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          a = {err_cnt, code_act, lock, bal_err, disp_err, rd_out};
          check("rd_out",   64'(a[O_RD   +: LANES]), 64'(e[O_RD   +: LANES]));
          check("disp_err", 64'(a[O_DISP +: LANES]), 64'(e[O_DISP +: LANES]));
          check("bal_err",  64'(a[O_BAL  +: LANES]), 64'(e[O_BAL  +: LANES]));
          check("lock",     64'(a[O_LOCK +: LANES]), 64'(e[O_LOCK +: LANES]));
          check("code_err", 64'(a[O_CODE +: LANES]), 64'(e[O_CODE +: LANES]));
          check("err_cnt",  64'(a[O_CNT  +: CNT_W*LANES]), 64'(e[O_CNT +: CNT_W*LANES]));
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [LANES-1:0] v;
    logic [10*LANES-1:0] s;
    rst = 1'b1; sym_vld = '0; sym_in = '0; cnt_clr = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1, '0, '0, 1'b0);
    idle(2);

    // legal pair, then disparity error at RD-, then unbalanced symbol on lane 1
    send(0, K_M, 1'b0);
    send(0, K_P, 1'b0);
    send(0, K_P, 1'b0);
    idle(1);
    send(1, BAL7, 1'b0);
    idle(1);

    // lock acquisition, 3 bad + 1 good keeps lock, 4 bad drops it
    for (int k = 0; k < LOCK_GOOD; k++) send(0, good_sym(0), 1'b0);
    for (int k = 0; k < LOSS_ERR - 1; k++) send(0, BAD0, 1'b0);
    send(0, good_sym(0), 1'b0);
    for (int k = 0; k < LOSS_ERR; k++) send(0, BAD0, 1'b0);
    idle(1);

    // counter saturation, then clear colliding with an error
    for (int k = 0; k < 300; k++) send(2, BAD0, 1'b0);
    send(2, BAD0, 1'b1);
    send(2, BAD0, 1'b0);
    idle(1);

    // valid gaps inside a good run, then reset mid-run
    for (int k = 0; k < 8; k++) send(3, good_sym(3), 1'b0);
    idle(3);
    for (int k = 0; k < 8; k++) send(3, good_sym(3), 1'b0);
    for (int k = 0; k < 6; k++) send(3, good_sym(3), 1'b0);
    idle(2);
    for (int k = 0; k < 10; k++) send(3, good_sym(3), 1'b0);
    step(1'b1, 4'b1111, {K_P, K_P, K_P, K_P}, 1'b0);
    idle(1);

    // randomized traffic on all lanes
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < LANES; i++) s[10*i +: 10] = rand_sym(i);
      v = LANES'($urandom_range(0, (1 << LANES) - 1));
      step(($urandom_range(0, 499) == 0), v, s, ($urandom_range(0, 199) == 0));
    end

    running = 1'b0;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
